// File: rtl/dma_source_device_if.sv
// Signal bundle between dma_source_device, its ingest source and the DMA controller.
// The slave modport is the device's view; master is the environment's view.
interface dma_source_device_if #(
  parameter int BURST = 4,
  parameter int IDX_W = 4
);
  logic                fill_valid;
  logic [15:0]         fill_data;
  logic                fill_ready;
  logic                dma_begin_interrupt;
  logic [IDX_W-1:0]    dma_idx;
  logic [16*BURST-1:0] dma_data;
  logic                dma_writeM2;
  logic                M2busy;
  logic                dma_end_interrupt;
  logic                dev_busy;
  logic                xfer_error;

  modport master (
    output fill_valid, fill_data, dma_idx, dma_writeM2, M2busy, dma_end_interrupt,
    input  fill_ready, dma_begin_interrupt, dma_data, dev_busy, xfer_error
  );

  modport slave (
    input  fill_valid, fill_data, dma_idx, dma_writeM2, M2busy, dma_end_interrupt,
    output fill_ready, dma_begin_interrupt, dma_data, dev_busy, xfer_error
  );
endinterface

// File: rtl/dma_source_device.sv
// I/O device upstream of a DMA controller: buffers LENGTH ingest words, pulses the
// begin interrupt, serves BURST-word slices by index and supervises the transfer.
module dma_source_device #(
  parameter int LENGTH        = 12,
  parameter int BURST         = 4,
  parameter int TRIGGER_DELAY = 3,
  parameter int TIMEOUT       = 64,
  parameter int IDX_W         = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  dma_source_device_if.slave  io_bus
);

  localparam int AW        = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int NBEATS    = LENGTH / BURST;
  localparam int BEATS_MAX = NBEATS + 1;
  localparam int BW        = $clog2(BEATS_MAX + 1);
  localparam int DW        = (TRIGGER_DELAY > 0) ? $clog2(TRIGGER_DELAY + 1) : 1;
  localparam int TW        = $clog2(TIMEOUT + 1);
  localparam int SUM_W     = $clog2((1 << IDX_W) + BURST);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_WAIT = 2'd1,
    ST_IRQ  = 2'd2,
    ST_XFER = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [AW-1:0]       r_wr_ptr;
  logic [BW-1:0]       r_beats;
  logic [DW-1:0]       r_delay;
  logic [TW-1:0]       r_tmo;
  logic                r_xfer_error;
  logic [15:0]         r_buf [LENGTH];

  logic                w_accept;
  logic                w_last_accept;
  logic                w_beat;
  logic                w_end;
  logic                w_timeout;
  logic                w_delay_done;
  logic [SUM_W-1:0]    w_sum;
  logic [16*BURST-1:0] w_dma_data;

  assign w_accept      = (r_state == ST_FILL) && io_bus.fill_valid;
  assign w_last_accept = w_accept && (r_wr_ptr == AW'(LENGTH - 1));
  assign w_beat        = (r_state == ST_XFER) && io_bus.dma_writeM2 && !io_bus.M2busy;
  assign w_end         = (r_state == ST_XFER) && io_bus.dma_end_interrupt;
  // The end interrupt takes priority over a timeout landing in the same cycle.
  assign w_timeout     = (r_state == ST_XFER) && !io_bus.dma_end_interrupt &&
                         (r_tmo == TW'(TIMEOUT - 1));
  assign w_delay_done  = (r_state == ST_WAIT) && (r_delay == DW'(TRIGGER_DELAY - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_last_accept) begin
          if (TRIGGER_DELAY == 0) begin
            w_next_state = ST_IRQ;
          end else begin
            w_next_state = ST_WAIT;
          end
        end else begin
          w_next_state = ST_FILL;
        end
      end
      ST_WAIT: begin
        if (w_delay_done) begin
          w_next_state = ST_IRQ;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_IRQ: begin
        w_next_state = ST_XFER;
      end
      ST_XFER: begin
        if (w_end || w_timeout) begin
          w_next_state = ST_FILL;
        end else begin
          w_next_state = ST_XFER;
        end
      end
      default: begin
        w_next_state = ST_FILL;
      end
    endcase
  end

  always_comb begin
    io_bus.fill_ready          = 1'b0;
    io_bus.dma_begin_interrupt = 1'b0;
    io_bus.dev_busy            = 1'b1;
    case (r_state)
      ST_FILL: begin
        io_bus.fill_ready = 1'b1;
        io_bus.dev_busy   = 1'b0;
      end
      ST_WAIT: begin
        io_bus.dev_busy = 1'b1;
      end
      ST_IRQ: begin
        io_bus.dma_begin_interrupt = 1'b1;
      end
      ST_XFER: begin
        io_bus.dev_busy = 1'b1;
      end
      default: begin
        io_bus.dev_busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr     <= '0;
      r_beats      <= '0;
      r_delay      <= '0;
      r_tmo        <= '0;
      r_xfer_error <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last_accept) begin
          r_wr_ptr <= '0;
        end else begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
      end else if (w_end || w_timeout) begin
        r_wr_ptr <= '0;
      end

      if (r_state == ST_WAIT) begin
        r_delay <= r_delay + DW'(1);
      end else begin
        r_delay <= '0;
      end

      // beats saturates one past the expected count so overruns can never alias a good total.
      if ((r_state == ST_XFER) && !(w_end || w_timeout)) begin
        r_tmo <= r_tmo + TW'(1);
        if (w_beat && (r_beats != BW'(BEATS_MAX))) begin
          r_beats <= r_beats + BW'(1);
        end
      end else begin
        r_tmo   <= '0;
        r_beats <= '0;
      end

      if (w_end && (r_beats != BW'(NBEATS))) begin
        r_xfer_error <= 1'b1;
      end else if (w_timeout) begin
        r_xfer_error <= 1'b1;
      end else if (w_accept) begin
        r_xfer_error <= 1'b0;
      end
    end
  end

  // Buffer has no reset: contents survive Reset and are simply overwritten by the next fill.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_accept) begin
      r_buf[r_wr_ptr] <= io_bus.fill_data;
    end
  end

  always_comb begin
    w_dma_data = '0;
    w_sum      = '0;
    for (int k = 0; k < BURST; k++) begin
      w_sum = SUM_W'(io_bus.dma_idx) + SUM_W'(k);
      if (w_sum < SUM_W'(LENGTH)) begin
        w_dma_data[16*k +: 16] = r_buf[w_sum[AW-1:0]];
      end else begin
        w_dma_data[16*k +: 16] = 16'h0000;
      end
    end
  end

  assign io_bus.dma_data   = w_dma_data;
  assign io_bus.xfer_error = r_xfer_error;

endmodule

// File: tb/tb_dma_source_device.sv
// Randomized bench for dma_source_device: a transfer-level reference model is compared
// against every output on every falling edge, plus fixed expectations for key scenarios.
module tb_dma_source_device;
  localparam int LEN   = 12;
  localparam int BURST = 4;
  localparam int TD    = 3;
  localparam int TMO   = 64;
  localparam int NB    = LEN / BURST;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  dma_source_device_if #(.BURST(BURST), .IDX_W(4)) bus ();

  dma_source_device #(
    .LENGTH(LEN), .BURST(BURST), .TRIGGER_DELAY(TD), .TIMEOUT(TMO), .IDX_W(4)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a fill phase, then a count of cycles since the buffer became full.
  logic [15:0] m_buf   [LEN];
  bit          m_known [LEN];
  bit          m_fill  = 1'b1;
  int          m_words = 0;
  int          m_d     = 0;
  int          m_beats = 0;
  bit          m_err   = 1'b0;
  bit          m_valid = 1'b0;
  logic [15:0] exp_data [LEN];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int n;
    if (reset) begin
      m_fill = 1'b1; m_words = 0; m_d = 0; m_beats = 0; m_err = 1'b0;
    end else if (m_fill) begin
      if (bus.fill_valid) begin
        m_buf[m_words]   = bus.fill_data;
        m_known[m_words] = 1'b1;
        m_words++;
        m_err = 1'b0;
        if (m_words == LEN) begin
          m_fill = 1'b0; m_d = 1; m_beats = 0;
        end
      end
    end else if (m_d <= TD + 1) begin
      m_d++;
    end else begin
      n = m_d - TD - 1;
      if (bus.dma_end_interrupt) begin
        if (m_beats != NB) m_err = 1'b1;
        m_fill = 1'b1; m_words = 0;
      end else if (n == TMO) begin
        m_err = 1'b1;
        m_fill = 1'b1; m_words = 0;
      end else begin
        if (bus.dma_writeM2 && !bus.M2busy && m_beats < NB + 1) m_beats++;
        m_d++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      m_valid = 1'b1;
    end
  end

  // Compare process: every output, every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        int idx;
        chk("fill_ready", 64'(bus.fill_ready), 64'(m_fill));
        chk("dev_busy", 64'(bus.dev_busy), 64'(!m_fill));
        chk("begin_irq", 64'(bus.dma_begin_interrupt), 64'(!m_fill && m_d == TD + 1));
        chk("xfer_error", 64'(bus.xfer_error), 64'(m_err));
        for (int k = 0; k < BURST; k++) begin
          idx = int'(bus.dma_idx) + k;
          if (idx >= LEN) chk("dma_data_oob", 64'(bus.dma_data[16*k +: 16]), 64'h0);
          else if (m_known[idx]) chk("dma_data", 64'(bus.dma_data[16*k +: 16]), 64'(m_buf[idx]));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.dma_idx = 4'($urandom_range(0, 15));
      tick();
    end
  endtask

  task automatic push(input bit seq, input logic [15:0] base, input bit gaps,
                      input int first, input int count);
    int n = 0;
    int guard = 0;
    while (n < count && guard < 200) begin
      bus.dma_idx           = 4'($urandom_range(0, 15));
      bus.dma_end_interrupt = ($urandom_range(0, 3) == 0);
      bus.dma_writeM2       = 1'($urandom_range(0, 1));
      bus.M2busy            = 1'($urandom_range(0, 1));
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.fill_valid = 1'b0;
      end else begin
        bus.fill_valid = 1'b1;
        bus.fill_data  = seq ? base + 16'(first + n) : 16'($urandom);
        exp_data[first + n] = bus.fill_data;
        n++;
      end
      tick();
      guard++;
    end
    bus.fill_valid = 1'b0; bus.dma_end_interrupt = 1'b0;
    bus.dma_writeM2 = 1'b0; bus.M2busy = 1'b0;
  endtask

  // Waits for the begin pulse right after the final accept, then enters the first XFER cycle.
  task automatic wait_begin(input bit valid_in_wait);
    int lat = 0;
    bit found = 1'b0;
    if (valid_in_wait) begin
      bus.fill_valid = 1'b1;
      bus.fill_data  = 16'hDEAD;
    end
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (i == 1) chk("ready_drop", 64'(bus.fill_ready), 64'h0);
      if (bus.dma_begin_interrupt) begin
        found = 1'b1;
        lat = i;
      end
    end
    chk("begin_latency", 64'(lat), 64'(TD + 1));
    tick();
    bus.fill_valid = 1'b0;
  endtask

  task automatic beat(input logic [3:0] idx, input int stalls);
    bus.dma_idx     = idx;
    bus.dma_writeM2 = 1'b1;
    bus.M2busy      = 1'b1;
    for (int i = 0; i < stalls; i++) tick();
    bus.M2busy = 1'b0;
    tick();
    bus.dma_writeM2 = 1'b0;
  endtask

  task automatic end_irq();
    bus.dma_end_interrupt = 1'b1;
    tick();
    bus.dma_end_interrupt = 1'b0;
  endtask

  initial begin
    int nb;
    bus.fill_valid = 1'b0; bus.fill_data = 16'h0000; bus.dma_idx = 4'd0;
    bus.dma_writeM2 = 1'b0; bus.M2busy = 1'b0; bus.dma_end_interrupt = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(bus.fill_ready), 64'h1);
    chk("rst_busy", 64'(bus.dev_busy), 64'h0);
    chk("rst_err", 64'(bus.xfer_error), 64'h0);
    chk("rst_begin", 64'(bus.dma_begin_interrupt), 64'h0);

    // Nominal transfer with sequential data.
    push(1'b1, 16'h1000, 1'b0, 0, LEN);
    wait_begin(1'b0);
    bus.dma_idx = 4'd0;
    @(negedge clk);
    chk("t1_data_idx0", bus.dma_data, 64'h1003_1002_1001_1000);
    beat(4'd0, 0); beat(4'd4, 0); beat(4'd8, 0);
    end_irq();
    @(negedge clk);
    chk("t1_ready", 64'(bus.fill_ready), 64'h1);
    chk("t1_err", 64'(bus.xfer_error), 64'h0);

    // Stalled beat is not counted.
    push(1'b0, 16'h0000, 1'b0, 0, LEN);
    wait_begin(1'b0);
    beat(4'd0, 0); beat(4'd4, 2); beat(4'd8, 0);
    end_irq();
    @(negedge clk);
    chk("t2_err", 64'(bus.xfer_error), 64'h0);

    // Short transfer flags an error; the next accepted word clears it.
    push(1'b0, 16'h0000, 1'b0, 0, LEN);
    wait_begin(1'b0);
    beat(4'd0, 0); beat(4'd4, 0);
    end_irq();
    @(negedge clk);
    chk("t3_err", 64'(bus.xfer_error), 64'h1);
    push(1'b0, 16'h0000, 1'b0, 0, 1);
    @(negedge clk);
    chk("t3_clear", 64'(bus.xfer_error), 64'h0);
    push(1'b0, 16'h0000, 1'b0, 1, LEN - 1);

    // Timeout after exactly TMO XFER cycles.
    wait_begin(1'b0);
    idle(TMO - 1);
    @(negedge clk);
    chk("t4_busy_last", 64'(bus.dev_busy), 64'h1);
    tick();
    @(negedge clk);
    chk("t4_err", 64'(bus.xfer_error), 64'h1);
    chk("t4_ready", 64'(bus.fill_ready), 64'h1);

    // Reset mid-transfer, then a gappy fill with valid held during WAIT.
    push(1'b0, 16'h0000, 1'b0, 0, LEN);
    wait_begin(1'b0);
    beat(4'd0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_ready", 64'(bus.fill_ready), 64'h1);
    chk("t5_busy", 64'(bus.dev_busy), 64'h0);
    push(1'b0, 16'h0000, 1'b1, 0, LEN);
    wait_begin(1'b1);

    // Upper words past the buffer end read zero; end on the timeout cycle still wins.
    bus.dma_idx = 4'd10;
    @(negedge clk);
    chk("t6_hi_zero", 64'(bus.dma_data[63:32]), 64'h0);
    chk("t6_lo", 64'(bus.dma_data[31:0]), 64'({exp_data[11], exp_data[10]}));
    beat(4'd0, 0); beat(4'd4, 0); beat(4'd8, 0);
    idle(TMO - 4);
    end_irq();
    @(negedge clk);
    chk("t6_end_wins", 64'(bus.xfer_error), 64'h0);

    // Excess beats saturate and must flag an error.
    push(1'b0, 16'h0000, 1'b0, 0, LEN);
    wait_begin(1'b0);
    for (int i = 0; i < 11; i++) beat(4'($urandom_range(0, 15)), 0);
    end_irq();
    @(negedge clk);
    chk("sat_err", 64'(bus.xfer_error), 64'h1);

    // Randomized transfers: varying beat counts, stalls, gaps, timeouts and resets.
    for (int t = 0; t < 10; t++) begin
      push(1'b0, 16'h0000, 1'b1, 0, LEN);
      wait_begin(1'($urandom_range(0, 1)));
      nb = $urandom_range(0, 5);
      for (int b = 0; b < nb; b++) begin
        beat(4'($urandom_range(0, 15)), $urandom_range(0, 2));
        idle($urandom_range(0, 2));
      end
      case ($urandom_range(0, 5))
        0: idle(TMO + 2);
        1: begin reset = 1'b1; tick(); reset = 1'b0; end
        default: end_irq();
      endcase
      idle(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
